// File: rtl/logic_gates_pkg.sv
// Shared gate-select enum and a single-bit gate evaluator used by the lane cells.
package logic_gates_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XOR  = 3'd5,
    GATE_XNOR = 3'd6
  } gate_e;

  localparam int unsigned NUM_GATES = 7;

  // NOT looks at operand A only; the unused encoding evaluates to 0.
  function automatic logic gate_eval(input gate_e op, input logic a, input logic b);
    case (op)
      GATE_AND:  gate_eval = a & b;
      GATE_OR:   gate_eval = a | b;
      GATE_NOT:  gate_eval = ~a;
      GATE_NAND: gate_eval = ~(a & b);
      GATE_NOR:  gate_eval = ~(a | b);
      GATE_XOR:  gate_eval = a ^ b;
      GATE_XNOR: gate_eval = ~(a ^ b);
      default:   gate_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/logic_gates_cell.sv
// One-bit combinational slice: all seven gate values of a single operand lane.
module logic_gates_cell
  import logic_gates_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] y_o
);

  assign y_o[GATE_AND]  = gate_eval(GATE_AND,  a_i, b_i);
  assign y_o[GATE_OR]   = gate_eval(GATE_OR,   a_i, b_i);
  assign y_o[GATE_NOT]  = gate_eval(GATE_NOT,  a_i, b_i);
  assign y_o[GATE_NAND] = gate_eval(GATE_NAND, a_i, b_i);
  assign y_o[GATE_NOR]  = gate_eval(GATE_NOR,  a_i, b_i);
  assign y_o[GATE_XOR]  = gate_eval(GATE_XOR,  a_i, b_i);
  assign y_o[GATE_XNOR] = gate_eval(GATE_XNOR, a_i, b_i);

endmodule

// File: rtl/logic_gates.sv
// Bitwise two-operand gate evaluator: WIDTH lane cells feeding registered results
// with a one-cycle valid flag. Reset clears every result to 0, not to the gate of zero.
module logic_gates
  import logic_gates_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_gate,
  output logic [WIDTH-1:0] or_gate,
  output logic [WIDTH-1:0] not_gate,
  output logic [WIDTH-1:0] nand_gate,
  output logic [WIDTH-1:0] nor_gate,
  output logic [WIDTH-1:0] xor_gate,
  output logic [WIDTH-1:0] xnor_gate
);

  logic [WIDTH-1:0] and_d, or_d, not_d, nand_d, nor_d, xor_d, xnor_d;
  logic [WIDTH-1:0] and_q, or_q, not_q, nand_q, nor_q, xor_q, xnor_q;
  logic             valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [NUM_GATES-1:0] cell_y;

    logic_gates_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .y_o (cell_y)
    );

    assign and_d[i]  = cell_y[GATE_AND];
    assign or_d[i]   = cell_y[GATE_OR];
    assign not_d[i]  = cell_y[GATE_NOT];
    assign nand_d[i] = cell_y[GATE_NAND];
    assign nor_d[i]  = cell_y[GATE_NOR];
    assign xor_d[i]  = cell_y[GATE_XOR];
    assign xnor_d[i] = cell_y[GATE_XNOR];
  end

  // Result registers load only on valid operands; rst wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      and_q   <= {WIDTH{1'b0}};
      or_q    <= {WIDTH{1'b0}};
      not_q   <= {WIDTH{1'b0}};
      nand_q  <= {WIDTH{1'b0}};
      nor_q   <= {WIDTH{1'b0}};
      xor_q   <= {WIDTH{1'b0}};
      xnor_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        and_q  <= and_d;
        or_q   <= or_d;
        not_q  <= not_d;
        nand_q <= nand_d;
        nor_q  <= nor_d;
        xor_q  <= xor_d;
        xnor_q <= xnor_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign and_gate  = and_q;
  assign or_gate   = or_q;
  assign not_gate  = not_q;
  assign nand_gate = nand_q;
  assign nor_gate  = nor_q;
  assign xor_gate  = xor_q;
  assign xnor_gate = xnor_q;

endmodule

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates at WIDTH=1 and WIDTH=8; result order in packed
// checks is {and, or, not, nand, nor, xor, xnor}.
module tb_logic_gates;

  logic clk = 1'b0;
  logic rst;
  logic v1, v8;
  logic a1, b1;
  logic [7:0] a8, b8;
  logic ov1, ov8;
  logic o1_and, o1_or, o1_not, o1_nand, o1_nor, o1_xor, o1_xnor;
  logic [7:0] o8_and, o8_or, o8_not, o8_nand, o8_nor, o8_xor, o8_xnor;
  logic [6:0]  r1;
  logic [55:0] r8;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign r1 = {o1_and, o1_or, o1_not, o1_nand, o1_nor, o1_xor, o1_xnor};
  assign r8 = {o8_and, o8_or, o8_not, o8_nand, o8_nor, o8_xor, o8_xnor};

  logic_gates #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .out_valid(ov1),
    .and_gate(o1_and), .or_gate(o1_or), .not_gate(o1_not), .nand_gate(o1_nand),
    .nor_gate(o1_nor), .xor_gate(o1_xor), .xnor_gate(o1_xnor)
  );

  logic_gates #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .out_valid(ov8),
    .and_gate(o8_and), .or_gate(o8_or), .not_gate(o8_not), .nand_gate(o8_nand),
    .nor_gate(o8_nor), .xor_gate(o8_xor), .xnor_gate(o8_xnor)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({ov1, r1} !== 8'h00) begin
        n_err++;
        $display("FAIL reset_w1 cyc%0d: got %h expected 00", c, {ov1, r1});
      end
      n_cmp++;
      if ({ov8, r8} !== 57'h0) begin
        n_err++;
        $display("FAIL reset_w8 cyc%0d: got %h expected 0", c, {ov8, r8});
      end
    end
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab [4];
    logic [6:0] exp_r [4];
    ab[0] = 2'b00; exp_r[0] = 7'b0011101;
    ab[1] = 2'b01; exp_r[1] = 7'b0111010;
    ab[2] = 2'b10; exp_r[2] = 7'b0101010;
    ab[3] = 2'b11; exp_r[3] = 7'b1100001;
    for (int k = 0; k < 4; k++) begin
      v1 = 1'b1; a1 = ab[k][1]; b1 = ab[k][0];
      tick();
      n_cmp++;
      if ({ov1, r1} !== {1'b1, exp_r[k]}) begin
        n_err++;
        $display("FAIL truth_ab%b: got %b expected %b", ab[k], {ov1, r1}, {1'b1, exp_r[k]});
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_hold();
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    tick();
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({ov1, r1} !== 8'b0_1100001) begin
        n_err++;
        $display("FAIL hold cyc%0d: got %b expected 01100001", c, {ov1, r1});
      end
    end
  endtask

  task automatic test_width8();
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    n_cmp++;
    if ({ov8, r8} !== {1'b1, 56'h30_FC_0F_CF_03_CC_33}) begin
      n_err++;
      $display("FAIL w8_F0_3C: got %h expected 130fc0fcf03cc33", {ov8, r8});
    end
    v8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
    tick();
    n_cmp++;
    if ({ov8, r8} !== {1'b0, 56'h30_FC_0F_CF_03_CC_33}) begin
      n_err++;
      $display("FAIL w8_hold: got %h expected 030fc0fcf03cc33", {ov8, r8});
    end
  endtask

  task automatic test_midstream_reset();
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    tick();
    n_cmp++;
    if ({ov1, r1} !== 8'b1_1100001) begin
      n_err++;
      $display("FAIL mid_pre: got %b expected 11100001", {ov1, r1});
    end
    rst = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    n_cmp++;
    if ({ov1, r1} !== 8'h00) begin
      n_err++;
      $display("FAIL mid_rst: got %b expected 00000000", {ov1, r1});
    end
    rst = 1'b0; v1 = 1'b0;
    tick();
    n_cmp++;
    if ({ov1, r1} !== 8'h00) begin
      n_err++;
      $display("FAIL mid_idle: got %b expected 00000000", {ov1, r1});
    end
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    n_cmp++;
    if ({ov1, r1} !== 8'b1_0111010) begin
      n_err++;
      $display("FAIL mid_resume: got %b expected 10111010", {ov1, r1});
    end
    v1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [55:0] exp_r;
    logic        exp_v;
    logic [7:0]  na, nb;
    logic        nv;
    rst = 1'b1; v8 = 1'b0;
    tick();
    rst = 1'b0;
    exp_r = 56'h0; exp_v = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      na = 8'($urandom); nb = 8'($urandom); nv = 1'($urandom_range(0, 3) != 0);
      a8 = na; b8 = nb; v8 = nv;
      if (nv) exp_r = {na & nb, na | nb, ~na, ~(na & nb), ~(na | nb), na ^ nb, ~(na ^ nb)};
      exp_v = nv;
      tick();
      n_cmp++;
      if ({ov8, r8} !== {exp_v, exp_r}) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h expected %h", c, {ov8, r8}, {exp_v, exp_r});
      end
    end
    v8 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #2;
    test_reset();
    test_truth_table();
    test_hold();
    test_width8();
    test_midstream_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
